// File: rtl/ysyx_25030085_ifu_pkg.sv
// Fetch-unit constants and FSM state type, shared with control and decode.
package ysyx_25030085_ifu_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] IFU_RESET_PC    = 32'h8000_0000;
    localparam logic [INST_W-1:0] IFU_EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } ifu_state_e;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ysyx_25030085_ifu.sv
// Instruction fetch unit: one outstanding memory request, a single-entry
// instruction buffer offered to decode, redirect handling and ebreak halt.
module ysyx_25030085_ifu
    import ysyx_25030085_ifu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = IFU_RESET_PC,
    parameter logic [INST_W-1:0] EBREAK_INST = IFU_EBREAK_INST
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [INST_W-1:0] mem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [31:0]       inst_cnt
);

    ifu_state_e        state;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst_buf;
    logic              discard;

    // Request is held off while reset is asserted even though state is already REQ.
    assign mem_req_valid = (state == S_REQ) && rst_n;
    assign mem_req_addr  = pc;
    assign inst_valid    = (state == S_HOLD);
    assign inst          = inst_buf;
    assign inst_pc       = pc;
    assign halted        = (state == S_HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            discard  <= 1'b0;
            inst_buf <= '0;
            inst_cnt <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc <= align_pc(redirect_pc);
                    end
                    if (mem_req_ready) begin
                        // A request issued alongside a redirect is stale; its reply must be drained.
                        discard <= redirect_valid;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc <= align_pc(redirect_pc);
                    end
                    if (mem_resp_valid) begin
                        discard <= 1'b0;
                        if (discard || redirect_valid) begin
                            state <= S_REQ;
                        end else begin
                            inst_buf <= mem_resp_data;
                            state    <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        inst_cnt <= inst_cnt + 32'd1;
                    end
                    if (redirect_valid) begin
                        pc    <= align_pc(redirect_pc);
                        state <= S_REQ;
                    end else if (inst_ready) begin
                        if (inst_buf == EBREAK_INST) begin
                            state <= S_HALT;
                        end else begin
                            pc    <= pc + 32'd4;
                            state <= S_REQ;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule
